adder_arbiter: RTL
==================

# adder_arbiter

Round-robin arbiter and sequencer that shares the single 8-bit adder datapath (8-bit A, 8-bit B -> 9-bit S) among NREQ independent requesters.
- Each requester presents an operand pair under a valid/ready handshake.
- The block grants one requester per cycle, forms the 9-bit sum, and holds it in a one-deep output register tagged with the requester index.
- A downstream consumer drains the result under its own valid/ready handshake.
- The block sits between the operand sources and the result sink.

## Interface
Parameters:
- NREQ, 4, number of requesters (2..8).
- IDW, 2, width of the requester-index tag; must be ≥ clog2(NREQ).

Ports:
- clk  input  1  rising-edge clock, single clock domain.
- rst  input  1  synchronous active-high reset.
- req_valid  input  NREQ  bit i: requester i has an operand pair.
- req_a  input  8*NREQ  operand A of requester i at bits [8i+7:8i].
- req_b  input  8*NREQ  operand B of requester i at bits [8i+7:8i].
- req_ready  output  NREQ  one-hot or zero; bit i: requester i's pair is accepted this cycle.
- res_valid  output  1  output register holds a result.
- res_sum  output  9  zero-extended sum A+B, bit 8 = carry.
- res_id  output  IDW  index of the requester that produced res_sum.
- res_ready  input  1  consumer accepts the result this cycle.
- txn_count  output  16  count of accepted requests, wraps modulo 2^16.

## Operation
- Reset (rst=1 at a clk edge):
  - res_valid=0, res_sum=0, res_id=0, txn_count=0.
  - Round-robin pointer ptr=0.
  - req_ready forced to all-zero while rst=1.
- can_accept = !res_valid || res_ready. The output register is empty, or it is being drained this cycle.
- Grant selection:
  - Search req_valid starting at index ptr, ascending, wrapping at NREQ-1 -> 0.
  - The first set bit is the grant g.
  - req_ready = one-hot(g) when can_accept=1 and any req_valid=1. Otherwise req_ready=0.
  - req_ready depends combinationally on req_valid, res_valid, res_ready and ptr. No other combinational path exists.
- Transfer: req_valid[g] && req_ready[g]. On a transfer:
  - res_sum <= {1'b0,req_a[g]} + {1'b0,req_b[g]}, full 9-bit result with no truncation.
  - res_id <= g.
  - res_valid <= 1.
  - ptr <= (g+1) mod NREQ.
  - txn_count <= txn_count+1. 0xFFFF wraps to 0x0000.
- No transfer:
  - ptr and txn_count hold.
  - If res_valid && res_ready, res_valid <= 0. res_sum and res_id keep their last values.
- Backpressure: while res_valid=1 && res_ready=0, res_sum, res_id and res_valid hold stable and req_ready=0.
- Simultaneous drain and accept (res_valid=1, res_ready=1, a request pending): the old result leaves and the new result loads in the same edge. res_valid stays 1.
- Requesters must hold req_a, req_b and req_valid stable until their transfer. The block does not check this.
- Reset mid-operation: a pending or held result is discarded. No stale result appears after reset.

## Timing
- Latency: a transfer at edge k makes res_valid=1 with the matching res_sum and res_id visible after edge k.
- Throughput: one result per cycle when res_ready is held at 1.
- Fairness: with all NREQ requesters continuously valid and res_ready=1, grants rotate 0,1,...,NREQ-1,0,... Any valid requester is granted within NREQ accepting cycles.
- First cycle after rst deasserts: a valid requester 0 is granted immediately, since res_valid=0.

## Test plan
- Reset: drive rst=1 for 2 cycles with req_valid=4'b1111. Required: req_ready=0, res_valid=0, res_sum=0, res_id=0, txn_count=0 throughout.
- Single request: requester 2 presents A=100, B=28 with res_ready=1. Required:
  - req_ready=4'b0100 for one cycle.
  - Next cycle res_valid=1, res_sum=128, res_id=2.
  - Following cycle res_valid=0.
  - txn_count=1.
- Carry and max: requester 0 presents A=255, B=255. Required: res_sum=510 (9'h1FE). Then requester 1 presents A=5, B=7. Required: res_sum=12, res_id=1.
- Round-robin: all four valid continuously, res_ready=1, 8 cycles. Required:
  - res_id sequence 0,1,2,3,0,1,2,3.
  - One-hot req_ready every cycle.
  - txn_count=8.
- Backpressure: a result is held and res_ready=0 for 3 cycles while requesters 1 and 3 are valid. Required:
  - req_ready=0 and res_sum/res_id unchanged for those cycles.
  - On res_ready=1, the drain and the next grant (lowest index ≥ ptr) happen in the same cycle, and res_valid stays 1.
- Reset mid-stream and wrap: preload txn_count near 0xFFFF by issuing 65535 transfers, then 1 more. Required: txn_count=0x0000. Then assert rst while res_valid=1. Required: res_valid=0 and ptr=0, shown by requester 0 being granted first afterward.

Source files
------------

// File: rtl/adder_arbiter.sv
// rtl/adder_arbiter.sv - round-robin arbiter sharing one 8-bit adder among NREQ requesters
//
// Ports:
//   clk, rst            rising-edge clock, synchronous active-high reset
//   req_valid/req_ready per-requester operand handshake (req_ready one-hot or zero)
//   req_a, req_b        packed 8-bit operands, requester i at bits [8i+7:8i]
//   res_valid/res_ready result handshake toward the consumer
//   res_sum, res_id     9-bit sum (bit 8 = carry) and index of the producing requester
//   txn_count           accepted-request counter, wraps modulo 2^16

module adder_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [8*NREQ-1:0] req_a,
  input  logic [8*NREQ-1:0] req_b,
  output logic [NREQ-1:0]   req_ready,
  output logic              res_valid,
  output logic [8:0]        res_sum,
  output logic [IDW-1:0]    res_id,
  input  logic              res_ready,
  output logic [15:0]       txn_count
);

  logic [IDW-1:0] ptr;
  logic [IDW-1:0] grant_idx;
  logic [IDW-1:0] ptr_next;
  logic           found;
  logic           can_accept;
  logic           xfer;
  logic [7:0]     op_a;
  logic [7:0]     op_b;

  // The output register can take a new result when it is empty or being
  // drained on this same edge.
  assign can_accept = !res_valid || res_ready;

  // Circular search starting at ptr; the first valid requester wins.
  always_comb begin
    int idx;
    idx       = 0;
    found     = 1'b0;
    grant_idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NREQ) begin
        idx = idx - NREQ;
      end
      if (!found && req_valid[idx]) begin
        found     = 1'b1;
        grant_idx = IDW'(idx);
      end
    end
  end

  assign xfer = found && can_accept && !rst;

  always_comb begin
    req_ready = '0;
    if (xfer) begin
      req_ready[grant_idx] = 1'b1;
    end
  end

  assign op_a     = req_a[int'(grant_idx)*8 +: 8];
  assign op_b     = req_b[int'(grant_idx)*8 +: 8];
  assign ptr_next = (int'(grant_idx) == NREQ - 1) ? '0 : grant_idx + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      res_valid <= 1'b0;
      res_sum   <= '0;
      res_id    <= '0;
      txn_count <= '0;
      ptr       <= '0;
    end else if (xfer) begin
      // A transfer overwrites the register, which also covers the
      // simultaneous drain-and-load case with res_valid staying high.
      res_sum   <= {1'b0, op_a} + {1'b0, op_b};
      res_id    <= grant_idx;
      res_valid <= 1'b1;
      ptr       <= ptr_next;
      txn_count <= txn_count + 16'd1;
    end else if (res_valid && res_ready) begin
      res_valid <= 1'b0;
    end
  end

endmodule
